// File: rtl/cn_commit_collector_pkg.sv
// Shared constants and helpers for the commitment collector: SM3 block/digest widths,
// the padding marker byte, and the padding-block builder.
// Pure declarations; no logic, latency or flow control.
package cn_commit_collector_pkg;

    localparam int unsigned BLK_W = 512;
    localparam int unsigned DIG_W = 256;

    localparam logic [7:0] SM3_PAD_MARKER = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_RELEASE = 3'd2,
        ST_STALL   = 3'd3,
        ST_PAD     = 3'd4,
        ST_FIN     = 3'd5
    } cc_state_e;

    // Message length is always a whole number of blocks, so the final SM3 block is
    // the marker byte, zero fill and the 64-bit big-endian bit length.
    function automatic logic [BLK_W-1:0] sm3_pad_block(input logic [63:0] bitlen);
        return {SM3_PAD_MARKER, 440'h0, bitlen};
    endfunction

endpackage

// File: rtl/cn_commit_collector.sv
// Sequences the per-party commitment hash unit, packs commitment pairs into SM3 blocks, then emits the pad block.
// Latency: >=3 cycles per party beyond hash latency; blocks leave from a single-entry output register.
// Backpressure: blk_data/blk_last held while blk_valid&&!blk_ready; a full register stalls the next party.
//
// Ports:
//   clk, reset (async, active-low)
//   start        one-cycle run request, ignored while busy or in the done cycle
//   busy/done    run in progress / one-cycle completion pulse
//   party_idx    party currently being hashed (selects seed/aux upstream)
//   cn_hstart    level request to the commitment hash unit
//   cn_done      level completion, held until cn_hstart drops
//   cn_hash      commitment value, valid while cn_done
//   blk_valid/blk_ready/blk_data/blk_last   block stream to the aggregation hash
module cn_commit_collector
    import cn_commit_collector_pkg::*;
#(
    parameter int unsigned NCOMMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [7:0]       party_idx,
    output logic             cn_hstart,
    input  logic             cn_done,
    input  logic [DIG_W-1:0] cn_hash,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_last
);

    localparam logic [8:0]       NCOMMIT_W = 9'(NCOMMIT);
    localparam logic [BLK_W-1:0] PAD_BLK   = sm3_pad_block(64'(NCOMMIT) * 64'd256);

    cc_state_e        state_q,     state_d;
    logic [7:0]       party_idx_q, party_idx_d;
    logic             half_q,      half_d;
    logic [DIG_W-1:0] hi_q,        hi_d;
    logic [BLK_W-1:0] blk_data_q,  blk_data_d;
    logic             blk_valid_q, blk_valid_d;
    logic             blk_last_q,  blk_last_d;
    logic             done_q,      done_d;

    logic xfer;
    logic last_party;

    assign xfer       = blk_valid_q && blk_ready;
    assign last_party = ({1'b0, party_idx_q} + 9'd1) == NCOMMIT_W;

    always_comb begin
        state_d     = state_q;
        party_idx_d = party_idx_q;
        half_d      = half_q;
        hi_d        = hi_q;
        blk_data_d  = blk_data_q;
        blk_valid_d = blk_valid_q;
        blk_last_d  = blk_last_q;
        done_d      = 1'b0;
        cn_hstart   = 1'b0;

        // Drain first; any load below in the same cycle takes precedence.
        if (xfer) begin
            blk_valid_d = 1'b0;
            blk_last_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                // done_q blocks a restart in the completion cycle.
                if (start && !done_q) begin
                    party_idx_d = 8'd0;
                    half_d      = 1'b0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                cn_hstart = 1'b1;
                if (cn_done) begin
                    if (!half_q) begin
                        hi_d   = cn_hash;
                        half_d = 1'b1;
                    end else begin
                        blk_data_d  = {hi_q, cn_hash};
                        blk_valid_d = 1'b1;
                        blk_last_d  = 1'b0;
                        half_d      = 1'b0;
                    end
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!cn_done) begin
                    if (last_party) begin
                        // party_idx stays at NCOMMIT-1 until the next start.
                        state_d = ST_PAD;
                    end else begin
                        party_idx_d = party_idx_q + 8'd1;
                        // A full register right after a pair completes means the
                        // next pair could land before the block leaves.
                        if (blk_valid_q && !half_q) begin
                            state_d = ST_STALL;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                end
            end
            ST_STALL: begin
                // Also exits if the block already left on the cycle we entered.
                if (!blk_valid_q || blk_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_PAD: begin
                if (!blk_valid_q) begin
                    blk_data_d  = PAD_BLK;
                    blk_valid_d = 1'b1;
                    blk_last_d  = 1'b1;
                    state_d     = ST_FIN;
                end
            end
            ST_FIN: begin
                if (xfer) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            party_idx_q <= 8'd0;
            half_q      <= 1'b0;
            hi_q        <= '0;
            blk_data_q  <= '0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            party_idx_q <= party_idx_d;
            half_q      <= half_d;
            hi_q        <= hi_d;
            blk_data_q  <= blk_data_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign party_idx = party_idx_q;
    assign blk_valid = blk_valid_q;
    assign blk_data  = blk_data_q;
    assign blk_last  = blk_last_q;

endmodule

// File: doc/cn_commit_collector.md
# cn_commit_collector

Sequencer and packer downstream of the per-party commitment hash unit (SM3 over seed‖aux‖salt). Drives that unit once per party, captures each 256-bit commitment C_n, and packs consecutive pairs into 512-bit SM3 message blocks. After the last pair it emits the SM3 padding block. The block stream feeds the commitment-aggregation hash stage.

## Interface
- NCOMMIT, 16, number of parties/commitments; even, 2..254
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle pulse; begins a collection run; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final block handshake
- party_idx  out  8  index n of the commitment being generated; upstream uses it to select seed/aux
- cn_hstart  out  1  level start to the commitment hash unit
- cn_done  in  1  level completion from the commitment hash unit; stays high until cn_hstart drops
- cn_hash  in  256  commitment value; valid while cn_done=1
- blk_valid  out  1  blk_data holds a message block
- blk_ready  in  1  downstream accepts; transfer when blk_valid&&blk_ready
- blk_data  out  512  message block, first byte in bits [511:504]
- blk_last  out  1  high with the padding block (final block)

## Operation
- States: IDLE, REQ, RELEASE, STALL, PAD, FIN.
- IDLE: on start, clear party_idx and the half flag; go to REQ.
- REQ: cn_hstart=1. When cn_done=1, latch cn_hash:
  - half flag=0: store the value in the high half register and set the flag.
  - half flag=1: load {high_half, cn_hash} into the output register, set blk_valid, clear the flag.
  - Then go to RELEASE.
- RELEASE: cn_hstart=0. Wait for cn_done=0, then increment party_idx:
  - party_idx+1==NCOMMIT: go to PAD.
  - Else, if blk_valid=1 and the half flag=0 (a second pair would collide): go to STALL.
  - Else: go to REQ.
- STALL: cn_hstart=0. Go to REQ the cycle after the pending block transfers.
- PAD: once the output register is empty, load {8'h80, 440'h0, 64'd(NCOMMIT*256)} with blk_last=1.
- FIN: after the last block transfers, pulse done and return to IDLE.
- The output register is single-entry. blk_data and blk_last are held stable while blk_valid&&!blk_ready.
- Blocks per run: NCOMMIT/2 data blocks plus 1 padding block.
- A start pulse while busy=1 is ignored. A start in the same cycle as done is also ignored.

## Timing
- Reset values: busy=0, done=0, party_idx=0, cn_hstart=0, blk_valid=0, blk_last=0, blk_data=0; state IDLE.
- cn_hstart rises the cycle after start, and again the cycle after the previous RELEASE/STALL exit.
- cn_hash is captured on the first clk edge where state=REQ and cn_done=1.
- cn_hstart falls on the next cycle.
- blk_valid rises the cycle after the second capture of a pair.
- cn_done is expected low at most 2 cycles after cn_hstart falls. There is no timeout.
- Minimum overhead per party: 3 cycles beyond the hash latency.
- done pulses exactly 1 cycle after the blk_last handshake.
- Reset mid-run: returns to IDLE immediately and asynchronously. cn_hstart drops, and any partial block is discarded.
- party_idx holds its final value (NCOMMIT-1) until the next start.

## Structure
- Shared package:
  - SM3 pad marker 8'h80
  - block width 512, digest width 256
  - function for the padding-block constant from the bit length
- Single module, no sub-modules. The SM3 core is not instantiated here.

## Test plan
- NCOMMIT=4; the model returns cn_hash=n+1 replicated, with cn_done after 10 cycles; blk_ready=1 → expect:
  - blocks {C0,C1} and {C2,C3}
  - padding block ending in 64'd1024 with blk_last=1
  - done one cycle after the padding handshake
- Same setup with blk_ready=0 for 50 cycles after the first block → expect:
  - no cn_hstart for party 2 until that block transfers (STALL)
  - blk_data stable throughout
- Back-pressure on the padding block → expect:
  - blk_last/blk_data held
  - done only after blk_ready=1
- start pulse while busy, at party 1 → expect no effect; the run completes with the normal 3 blocks.
- Reset asserted while cn_hstart=1 at party 2 → expect:
  - all outputs at reset values
  - a fresh start restarts at party_idx=0
- cn_done held high 3 extra cycles after cn_hstart falls → expect no double capture and party_idx incremented once.
